// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: request/response bundle between the execute stage and the
// multiply/divide unit.
//   master (execute stage): drives in_valid, in_op, in_src1, in_src2, cancel;
//                           observes in_ready, busy, done, hi, lo
//   slave  (mul_div_unit) : the reverse
interface mul_div_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_op;
    logic [XLEN-1:0] in_src1;
    logic [XLEN-1:0] in_src2;
    logic            cancel;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    modport master (
        output in_valid, in_op, in_src1, in_src2, cancel,
        input  in_ready, busy, done, hi, lo
    );

    modport slave (
        input  in_valid, in_op, in_src1, in_src2, cancel,
        output in_ready, busy, done, hi, lo
    );
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: multiply/divide unit with architectural HI/LO registers.
//   MULT/MULTU on a MUL_STAGES-deep multiplier pipeline, DIV/DIVU on an
//   iterative restoring radix-2 divider (one quotient bit per cycle),
//   MTHI/MTLO direct writes. Reserved ops 6/7 complete as no-ops.
// Ports:
//   clk    - rising-edge clock
//   resetn - asynchronous active-low reset
//   bus    - slave side of mul_div_unit_if (valid/ready request, cancel,
//            busy, one-cycle done pulse, hi/lo registers)
module mul_div_unit #(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic           clk,
    input  logic           resetn,
    mul_div_unit_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } state_t;

    localparam int CW = $clog2(XLEN + MUL_STAGES + 1);

    state_t            state;
    logic [CW-1:0]     count;
    logic [XLEN-1:0]   hi_q, lo_q;
    logic              done_q;

    // divider datapath: dvd_q shifts the dividend out and the quotient in
    logic [XLEN-1:0]   dvd_q, rem, dvs;
    logic              s1, s2;

    logic              in_ready;
    logic              accept;

    assign in_ready = (state == S_IDLE) && !bus.cancel;
    assign accept   = bus.in_valid && in_ready;

    // ---------------- multiplier ----------------
    // Product of the current inputs enters the pipe every cycle; only the
    // value captured in the accept cycle reaches the last stage when the
    // MUL state finishes, so the pipe needs no enable.
    logic              mul_signed;
    logic [2*XLEN-1:0] mul_a, mul_b, mul_p;
    logic [2*XLEN-1:0] mul_pipe [MUL_STAGES];

    assign mul_signed = (bus.in_op == 3'd0);
    assign mul_a = {{XLEN{mul_signed & bus.in_src1[XLEN-1]}}, bus.in_src1};
    assign mul_b = {{XLEN{mul_signed & bus.in_src2[XLEN-1]}}, bus.in_src2};
    assign mul_p = mul_a * mul_b;

    always_ff @(posedge clk) begin
        mul_pipe[0] <= mul_p;
        for (int unsigned i = 1; i < MUL_STAGES; i++)
            mul_pipe[i] <= mul_pipe[i-1];
    end

    // ---------------- divider ----------------
    logic              div_signed;
    logic              src1_neg, src2_neg;
    logic [XLEN-1:0]   abs1, abs2;
    logic [XLEN:0]     rem_sh;
    logic              ge;
    logic [XLEN-1:0]   rem_nx, q_nx, q_fix, r_fix;

    assign div_signed = (bus.in_op == 3'd2);
    assign src1_neg   = div_signed & bus.in_src1[XLEN-1];
    assign src2_neg   = div_signed & bus.in_src2[XLEN-1];
    assign abs1       = src1_neg ? -bus.in_src1 : bus.in_src1;
    assign abs2       = src2_neg ? -bus.in_src2 : bus.in_src2;

    // Restoring step; the remainder after subtraction is always < dvs, so
    // the XLEN-bit subtraction cannot lose information.
    assign rem_sh = {rem, dvd_q[XLEN-1]};
    assign ge     = rem_sh >= {1'b0, dvs};
    assign rem_nx = ge ? (rem_sh[XLEN-1:0] - dvs) : rem_sh[XLEN-1:0];
    assign q_nx   = {dvd_q[XLEN-2:0], ge};
    assign q_fix  = (s1 ^ s2) ? -q_nx : q_nx;
    assign r_fix  = s1 ? -rem_nx : rem_nx;

    // ---------------- control ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= S_IDLE;
            count  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
            dvd_q  <= '0;
            rem    <= '0;
            dvs    <= '0;
            s1     <= 1'b0;
            s2     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        case (bus.in_op)
                            3'd0, 3'd1: begin
                                state <= S_MUL;
                                count <= CW'(MUL_STAGES - 1);
                            end
                            3'd2, 3'd3: begin
                                state <= S_DIV;
                                count <= CW'(XLEN - 1);
                                dvd_q <= abs1;
                                dvs   <= abs2;
                                rem   <= '0;
                                s1    <= src1_neg;
                                s2    <= src2_neg;
                            end
                            3'd4: begin
                                hi_q   <= bus.in_src1;
                                done_q <= 1'b1;
                            end
                            3'd5: begin
                                lo_q   <= bus.in_src1;
                                done_q <= 1'b1;
                            end
                            default: done_q <= 1'b1;
                        endcase
                    end
                end
                S_MUL: begin
                    if (bus.cancel) begin
                        state <= S_IDLE;
                    end else if (count == '0) begin
                        {hi_q, lo_q} <= mul_pipe[MUL_STAGES-1];
                        done_q       <= 1'b1;
                        state        <= S_IDLE;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                S_DIV: begin
                    if (bus.cancel) begin
                        state <= S_IDLE;
                    end else begin
                        rem   <= rem_nx;
                        dvd_q <= q_nx;
                        if (count == '0) begin
                            lo_q   <= q_fix;
                            hi_q   <= r_fix;
                            done_q <= 1'b1;
                            state  <= S_IDLE;
                        end else begin
                            count <= count - 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.busy     = (state != S_IDLE);
    assign bus.done     = done_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: scoreboard bench for mul_div_unit (XLEN=32, MUL_STAGES=2).
// Driver pushes expected {hi, lo, latency} from a plain-arithmetic model at
// accept; a monitor pops and compares on every done pulse.
module tb_mul_div_unit;
    localparam int XLEN = 32;
    localparam int MS   = 2;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mul_div_unit_if #(.XLEN(XLEN)) bus ();

    mul_div_unit #(.XLEN(XLEN), .MUL_STAGES(MS)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int unsigned acc;
        int unsigned lat;
        logic [2:0]  op;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    int          passes = 0;
    int          total  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic int unsigned latency(input logic [2:0] op);
        if (op <= 3'd1) return MS + 1;
        if (op <= 3'd3) return XLEN + 1;
        return 1;
    endfunction

    // Reference behaviour in plain arithmetic.
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        case (op)
            3'd0: begin
                p = 64'(longint'($signed(a)) * longint'($signed(b)));
                {m_hi, m_lo} = p;
            end
            3'd1: begin
                p = {32'd0, a} * {32'd0, b};
                {m_hi, m_lo} = p;
            end
            3'd2: begin
                if (b == 32'd0) begin
                    m_hi = a;
                    m_lo = ($signed(a) < 0) ? 32'd1 : 32'hFFFF_FFFF;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m_lo = 32'h8000_0000;
                    m_hi = 32'd0;
                end else begin
                    m_lo = $signed(a) / $signed(b);
                    m_hi = $signed(a) % $signed(b);
                end
            end
            3'd3: begin
                if (b == 32'd0) begin
                    m_lo = 32'hFFFF_FFFF;
                    m_hi = a;
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
            default: ;
        endcase
    endfunction

    // Issue one request; returns at accept-edge + 1. track=0 for ops that
    // will be cancelled or reset away.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit track, output int unsigned acc);
        int unsigned w = 0;
        exp_t e;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_src1  = a;
        bus.in_src2  = b;
        while (!bus.in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        acc = cyc;
        if (!bus.in_ready) begin
            check("accept_timeout", 64'd0, 64'd1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        if (track) begin
            model(op, a, b);
            e.hi  = m_hi;
            e.lo  = m_lo;
            e.acc = acc;
            e.lat = latency(op);
            e.op  = op;
            sbq.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (resetn && bus.done) begin
            if (sbq.size() == 0) begin
                check("spurious_done", 64'd1, 64'd0);
            end else begin
                mon_e = sbq.pop_front();
                check($sformatf("hi_op%0d", mon_e.op), bus.hi, mon_e.hi);
                check($sformatf("lo_op%0d", mon_e.op), bus.lo, mon_e.lo);
                check($sformatf("latency_op%0d", mon_e.op), cyc - mon_e.acc, mon_e.lat);
            end
        end
    end

    task automatic cancel_div(input int unsigned k);
        int unsigned acc;
        issue(3'd3, 32'd1000, 32'd3, 1'b0, acc);
        repeat (k - 1) @(posedge clk);
        @(negedge clk);
        bus.cancel = 1'b1;
        check($sformatf("busy_before_cancel_c%0d", k), bus.busy, 1);
        @(posedge clk);
        #1 bus.cancel = 1'b0;
        @(negedge clk);
        check($sformatf("busy_after_cancel_c%0d", k), bus.busy, 0);
        repeat (40) @(negedge clk);
        check($sformatf("hi_kept_c%0d", k), bus.hi, m_hi);
        check($sformatf("lo_kept_c%0d", k), bus.lo, m_lo);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned acc1, acc2, w;
        resetn       = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_op    = '0;
        bus.in_src1  = '0;
        bus.in_src2  = '0;
        bus.cancel   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_hi", bus.hi, 0);
        check("rst_lo", bus.lo, 0);
        check("rst_in_ready", bus.in_ready, 1);
        resetn = 1'b1;

        // directed cases
        issue(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b1, acc1);
        issue(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b1, acc1);
        issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1, acc1);
        @(negedge clk);
        check("div_busy_c2", bus.busy, 1);
        issue(3'd3, 32'd100, 32'd7, 1'b1, acc1);
        issue(3'd3, 32'd5, 32'd0, 1'b1, acc1);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, acc1);
        issue(3'd2, 32'hFFFF_FFF0, 32'd0, 1'b1, acc1);
        issue(3'd6, 32'hDEAD_BEEF, 32'd0, 1'b1, acc1);

        // back-to-back MTHI/MTLO
        issue(3'd4, 32'h1234, 32'd0, 1'b1, acc1);
        issue(3'd5, 32'h5678, 32'd0, 1'b1, acc2);
        check("mt_back_to_back", acc2 - acc1, 1);
        repeat (2) @(negedge clk);
        check("mt_hi", bus.hi, 32'h1234);
        check("mt_lo", bus.lo, 32'h5678);

        // cancel in IDLE blocks acceptance
        @(negedge clk);
        bus.cancel = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_op = 3'd4;
        bus.in_src1 = 32'hBAD0_0000;
        #1 check("cancel_idle_ready", bus.in_ready, 0);
        @(posedge clk);
        #1 begin bus.cancel = 1'b0; bus.in_valid = 1'b0; end
        repeat (3) @(negedge clk);
        check("cancel_idle_hi", bus.hi, m_hi);

        cancel_div(10);
        cancel_div(32);

        // async reset in the middle of a divide
        issue(3'd2, 32'd77, 32'd5, 1'b0, acc1);
        repeat (4) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        check("midrst_busy", bus.busy, 0);
        check("midrst_done", bus.done, 0);
        check("midrst_hi", bus.hi, 0);
        check("midrst_lo", bus.lo, 0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        resetn = 1'b1;
        issue(3'd0, 32'd6, 32'd7, 1'b1, acc1);

        // randomized traffic
        for (int i = 0; i < 60; i++) begin
            issue(3'($urandom_range(0, 7)), pick(), pick(), 1'b1, acc1);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
        end

        // drain
        w = 0;
        while ((sbq.size() != 0 || bus.busy) && w < 200) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        check("scoreboard_drained", 64'(sbq.size()), 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
